// File: rtl/oc2_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// PC source selector encodings match what Decode drives on id_if_selpctype.
package oc2_pkg;

  localparam logic [1:0] PCSEL_BRANCH = 2'b00;  // pc-relative branch target
  localparam logic [1:0] PCSEL_REG    = 2'b01;  // jr: register target
  localparam logic [1:0] PCSEL_INDEX  = 2'b10;  // j/jal: pseudo-direct target
  localparam logic [1:0] PCSEL_EXC    = 2'b11;  // exception vector

  // sll $0,$0,0 -- what Decode sees when no instruction is issued.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1
  } fetch_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection for the fetch stage: picks the redirect target from the
// selector, applies alignment handling, and chooses between redirect target,
// pending target and sequential pc+4.
// Optional feature: FETCH_ALIGN_CHECK_EN (misaligned targets trap to EXC_VECTOR).
module pc_next_mux
  import oc2_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic [1:0]  selpctype,
  input  logic [31:0] pcimd2ext,
  input  logic [31:0] rega,
  input  logic [31:0] pcindex,
  input  logic        take_redirect,
  input  logic        pend,
  input  logic [31:0] ptgt,
  input  logic [31:0] pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic [31:0] target,
  output logic [31:0] npc
);

  logic [31:0] raw_target;

  // Raw target chosen by the Decode selector.
  always_comb begin
    raw_target = EXC_VECTOR;
    case (selpctype)
      PCSEL_BRANCH: raw_target = pcimd2ext;
      PCSEL_REG:    raw_target = rega;
      PCSEL_INDEX:  raw_target = pcindex;
      default:      raw_target = EXC_VECTOR;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Misaligned targets are replaced by the exception vector and flagged.
  always_comb begin
    misalign = 1'b0;
    target   = raw_target;
    if (raw_target[1:0] != 2'b00) begin
      target   = EXC_VECTOR;
      misalign = take_redirect;
    end
  end
`else
  // Without the check, low bits are simply dropped to keep fetches word aligned.
  always_comb begin
    target = {raw_target[31:2], 2'b00};
  end
`endif

  // A live redirect wins over a pending one; otherwise fall through sequentially.
  always_comb begin
    npc = pc + 32'd4;
    if (take_redirect) begin
      npc = target;
    end else if (pend) begin
      npc = ptgt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack memory port and
// loads the IF/ID register (instruction + PC+4) consumed by Decode.
// The instruction after a branch (delay slot) always issues; redirects that
// arrive while the fetch is still waiting are parked until the next ack.
// Optional feature: FETCH_ALIGN_CHECK_EN adds the if_exc_misalign port.
//
// Memory handshake: if_mem_req is high in every FETCH cycle with if_mem_addr
// stable; a transfer happens in exactly the cycle mem_if_ack=1 (which may be
// the first cycle of the request), and mem_if_data is only looked at then.
module fetch_unit
  import oc2_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        reset,
  output logic        if_mem_req,
  output logic [31:0] if_mem_addr,
  input  logic        mem_if_ack,
  input  logic [31:0] mem_if_data,
  output logic [31:0] if_id_instruc,
  output logic [31:0] if_id_nextpc,
  input  logic        id_if_selpcsource,
  input  logic [1:0]  id_if_selpctype,
  input  logic [31:0] id_if_pcimd2ext,
  input  logic [31:0] id_if_rega,
  input  logic [31:0] id_if_pcindex,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        if_exc_misalign,
`endif
  output logic [1:0]  debug_state
);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic [31:0]  ptgt;
  logic         pend;
  logic         valid;
  logic [31:0]  target;
  logic [31:0]  npc;
  logic         take_redirect;
  logic         fetching;

  // Redirects only count when Decode holds a real (non-bubble) instruction.
  assign take_redirect = valid & id_if_selpcsource;
  assign fetching      = (state == ST_FETCH);
  assign if_mem_addr   = pc;
  assign debug_state   = state;

  pc_next_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_next_mux (
    .selpctype     (id_if_selpctype),
    .pcimd2ext     (id_if_pcimd2ext),
    .rega          (id_if_rega),
    .pcindex       (id_if_pcindex),
    .take_redirect (take_redirect),
    .pend          (pend),
    .ptgt          (ptgt),
    .pc            (pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign      (if_exc_misalign),
`endif
    .target        (target),
    .npc           (npc)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and request: one idle cycle out of reset, then fetch forever.
  always_comb begin
    state_next = state;
    if_mem_req = 1'b0;
    case (state)
      ST_IDLE:  state_next = ST_FETCH;
      ST_FETCH: if_mem_req = 1'b1;
      default:  state_next = ST_IDLE;
    endcase
  end

  // PC, pending redirect and IF/ID register update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_PC;
      pend          <= 1'b0;
      ptgt          <= RESET_PC;
      valid         <= 1'b0;
      if_id_instruc <= NOP_INSTR;
      if_id_nextpc  <= 32'h0000_0000;
    end else if (fetching) begin
      if (mem_if_ack) begin
        if_id_instruc <= mem_if_data;
        if_id_nextpc  <= pc + 32'd4;
        valid         <= 1'b1;
        pc            <= npc;
        pend          <= 1'b0;
      end else begin
        if_id_instruc <= NOP_INSTR;
        valid         <= 1'b0;
        if (take_redirect) begin
          pend <= 1'b1;
          ptgt <= target;
        end
      end
    end
  end

endmodule
